// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel port among NUM_CLIENTS drawing engines.
// Optional coordinate clipping with a clip counter is enabled by defining VGA_PLOT_CLIP_EN.
module vga_plot_arbiter #(
  parameter int NUM_CLIENTS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req,
  output logic [NUM_CLIENTS-1:0]   gnt,
  input  logic [8*NUM_CLIENTS-1:0] cl_x,
  input  logic [7*NUM_CLIENTS-1:0] cl_y,
  input  logic [3*NUM_CLIENTS-1:0] cl_colour,
  input  logic [NUM_CLIENTS-1:0]   cl_plot,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     busy
`ifdef VGA_PLOT_CLIP_EN
  ,
  output logic [15:0]              clip_count
`endif
);

  localparam int PW = $clog2(NUM_CLIENTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rrPtr_q, rrPtr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [7:0]             vgaX_q, vgaX_d;
  logic [6:0]             vgaY_q, vgaY_d;
  logic [2:0]             vgaColour_q, vgaColour_d;
  logic                   vgaPlot_q, vgaPlot_d;
`ifdef VGA_PLOT_CLIP_EN
  logic [15:0]            clipCount_q, clipCount_d;
`endif

  logic [7:0] xArr      [NUM_CLIENTS];
  logic [6:0] yArr      [NUM_CLIENTS];
  logic [2:0] colourArr [NUM_CLIENTS];

  logic [PW-1:0] sel;
  logic          selFound;
  logic          ownerReq;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : gUnpack
    assign xArr[i]      = cl_x[8*i +: 8];
    assign yArr[i]      = cl_y[7*i +: 7];
    assign colourArr[i] = cl_colour[3*i +: 3];
  end

  assign ownerReq = req[owner_q];

  // First requester at or above rrPtr, wrapping; the candidate index is folded explicitly
  // so non-power-of-two client counts never scan a nonexistent client.
  always_comb begin
    int idx;
    logic [PW-1:0] cand;
    idx      = 0;
    cand     = '0;
    sel      = '0;
    selFound = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      cand = PW'(idx);
      if (!selFound && req[cand]) begin
        selFound = 1'b1;
        sel      = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      vgaX_q      <= '0;
      vgaY_q      <= '0;
      vgaColour_q <= '0;
      vgaPlot_q   <= 1'b0;
`ifdef VGA_PLOT_CLIP_EN
      clipCount_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      vgaX_q      <= vgaX_d;
      vgaY_q      <= vgaY_d;
      vgaColour_q <= vgaColour_d;
      vgaPlot_q   <= vgaPlot_d;
`ifdef VGA_PLOT_CLIP_EN
      clipCount_q <= clipCount_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (selFound) begin
          state_d = GRANT;
          owner_d = sel;
        end
      end
      GRANT: begin
        if (!ownerReq) begin
          state_d = IDLE;
          rrPtr_d = (owner_q == PW'(NUM_CLIENTS - 1)) ? '0 : owner_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the owner's slice is ever forwarded; other clients' strobes are ignored.
  always_comb begin
    gnt_d       = '0;
    vgaX_d      = vgaX_q;
    vgaY_d      = vgaY_q;
    vgaColour_d = vgaColour_q;
    vgaPlot_d   = 1'b0;
`ifdef VGA_PLOT_CLIP_EN
    clipCount_d = clipCount_q;
`endif
    if (state_q == IDLE) begin
      if (selFound) gnt_d[sel] = 1'b1;
    end else if (ownerReq) begin
      gnt_d = gnt_q;
`ifdef VGA_PLOT_CLIP_EN
      if (cl_plot[owner_q] && (xArr[owner_q] > 8'd159 || yArr[owner_q] > 7'd119)) begin
        if (clipCount_q != 16'hFFFF) clipCount_d = clipCount_q + 16'd1;
      end else begin
        vgaX_d      = xArr[owner_q];
        vgaY_d      = yArr[owner_q];
        vgaColour_d = colourArr[owner_q];
        vgaPlot_d   = cl_plot[owner_q];
      end
`else
      vgaX_d      = xArr[owner_q];
      vgaY_d      = yArr[owner_q];
      vgaColour_d = colourArr[owner_q];
      vgaPlot_d   = cl_plot[owner_q];
`endif
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q == GRANT);
  assign vga_x      = vgaX_q;
  assign vga_y      = vgaY_q;
  assign vga_colour = vgaColour_q;
  assign vga_plot   = vgaPlot_q;
`ifdef VGA_PLOT_CLIP_EN
  assign clip_count = clipCount_q;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with a pixel scoreboard: expected pixels are queued
// when a granted client strobes plot and popped when the adapter port shows vga_plot.
module tb_vga_plot_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [8*N-1:0] clX;
  logic [7*N-1:0] clY;
  logic [3*N-1:0] clColour;
  logic [N-1:0]   clPlot;
  logic [7:0]     vgaX;
  logic [6:0]     vgaY;
  logic [2:0]     vgaColour;
  logic           vgaPlot;
  logic           busy;
`ifdef VGA_PLOT_CLIP_EN
  logic [15:0]    clipCount;
`endif

  int checks   = 0;
  int failures = 0;
  logic [17:0] pixelQ [$];

  vga_plot_arbiter #(.NUM_CLIENTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .cl_x       (clX),
    .cl_y       (clY),
    .cl_colour  (clColour),
    .cl_plot    (clPlot),
    .vga_x      (vgaX),
    .vga_y      (vgaY),
    .vga_colour (vgaColour),
    .vga_plot   (vgaPlot),
    .busy       (busy)
`ifdef VGA_PLOT_CLIP_EN
    ,
    .clip_count (clipCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] c, input logic p);
    clX[8*idx +: 8]      = x;
    clY[7*idx +: 7]      = y;
    clColour[3*idx +: 3] = c;
    clPlot[idx]          = p;
  endtask

  task automatic expectPixel(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    pixelQ.push_back({x, y, c});
  endtask

  // Every forwarded pixel must match the oldest outstanding expected pixel.
  always @(negedge clk) begin
    if (vgaPlot === 1'b1) begin
      checks++;
      if (pixelQ.size() == 0) begin
        failures++;
        $error("[TB] FAIL unexpected_pixel observed=%0h expected=none", {vgaX, vgaY, vgaColour});
      end else begin
        logic [17:0] exp;
        exp = pixelQ.pop_front();
        assert ({vgaX, vgaY, vgaColour} === exp) else begin
          failures++;
          $error("[TB] FAIL pixel observed=%0h expected=%0h", {vgaX, vgaY, vgaColour}, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; clX = '0; clY = '0; clColour = '0; clPlot = '0;
    tick(2);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_plot", 32'(vgaPlot), 32'd0);
    checkOutput("reset_x", 32'(vgaX), 32'd0);
    checkOutput("reset_y", 32'(vgaY), 32'd0);
    checkOutput("reset_colour", 32'(vgaColour), 32'd0);
    rst = 1'b0;

    $display("[TB] single client");
    req = 3'b010;
    tick();
    checkOutput("single_gnt", 32'(gnt), 32'b010);
    checkOutput("single_busy", 32'(busy), 32'd1);
    applyStimulus(1, 8'd10, 7'd20, 3'b101, 1'b1);
    expectPixel(8'd10, 7'd20, 3'b101);
    tick();
    applyStimulus(1, 8'd0, 7'd0, 3'b000, 1'b0);
    req = 3'b000;
    tick();
    checkOutput("single_release_gnt", 32'(gnt), 32'd0);
    checkOutput("single_release_busy", 32'(busy), 32'd0);

    $display("[TB] simultaneous requests");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b111;
    tick();
    checkOutput("sim_first_gnt", 32'(gnt), 32'b001);
    applyStimulus(0, 8'd1, 7'd2, 3'b001, 1'b1);
    expectPixel(8'd1, 7'd2, 3'b001);
    tick();
    applyStimulus(0, 8'd0, 7'd0, 3'b000, 1'b0);
    req = 3'b110;
    tick();
    checkOutput("sim_dead1_gnt", 32'(gnt), 32'd0);
    tick();
    checkOutput("sim_second_gnt", 32'(gnt), 32'b010);
    applyStimulus(1, 8'd2, 7'd3, 3'b010, 1'b1);
    expectPixel(8'd2, 7'd3, 3'b010);
    tick();
    applyStimulus(1, 8'd0, 7'd0, 3'b000, 1'b0);
    req = 3'b100;
    tick();
    checkOutput("sim_dead2_gnt", 32'(gnt), 32'd0);
    tick();
    checkOutput("sim_third_gnt", 32'(gnt), 32'b100);
    req = 3'b000;
    tick();
    checkOutput("sim_third_release", 32'(gnt), 32'd0);

    $display("[TB] isolation");
    req = 3'b001;
    tick();
    checkOutput("iso_gnt", 32'(gnt), 32'b001);
    req = 3'b101;
    applyStimulus(0, 8'd7, 7'd8, 3'b011, 1'b1);
    applyStimulus(2, 8'd50, 7'd9, 3'b111, 1'b1);
    expectPixel(8'd7, 7'd8, 3'b011);
    tick();
    applyStimulus(0, 8'd7, 7'd8, 3'b011, 1'b0);
    tick(2);
    checkOutput("iso_no_preempt", 32'(gnt), 32'b001);
    checkOutput("iso_x_held", 32'(vgaX), 32'd7);
    checkOutput("iso_plot_low", 32'(vgaPlot), 32'd0);
    applyStimulus(2, 8'd0, 7'd0, 3'b000, 1'b0);
    req = 3'b100;
    tick();
    checkOutput("iso_release", 32'(gnt), 32'd0);
    tick();
    checkOutput("iso_next_gnt", 32'(gnt), 32'b100);

    $display("[TB] wrap");
    req = 3'b111;
    tick();
    checkOutput("wrap_hold", 32'(gnt), 32'b100);
    req = 3'b011;
    tick();
    checkOutput("wrap_dead", 32'(gnt), 32'd0);
    tick();
    checkOutput("wrap_gnt", 32'(gnt), 32'b001);
    req = 3'b010;
    tick();
    checkOutput("wrap_release", 32'(gnt), 32'd0);
    tick();
    checkOutput("edge_gnt", 32'(gnt), 32'b010);

`ifdef VGA_PLOT_CLIP_EN
    $display("[TB] clipping");
    checkOutput("clip_count_zero", 32'(clipCount), 32'd0);
    applyStimulus(1, 8'd160, 7'd0, 3'b110, 1'b1);
    tick();
    checkOutput("clip_drop_plot", 32'(vgaPlot), 32'd0);
    checkOutput("clip_count_one", 32'(clipCount), 32'd1);
    applyStimulus(1, 8'd5, 7'd119, 3'b100, 1'b1);
    expectPixel(8'd5, 7'd119, 3'b100);
    tick();
    checkOutput("clip_count_hold", 32'(clipCount), 32'd1);
`else
    $display("[TB] unclipped edge coordinates");
    applyStimulus(1, 8'd160, 7'd127, 3'b110, 1'b1);
    expectPixel(8'd160, 7'd127, 3'b110);
    tick();
    applyStimulus(1, 8'd5, 7'd119, 3'b100, 1'b1);
    expectPixel(8'd5, 7'd119, 3'b100);
    tick();
`endif
    applyStimulus(1, 8'd0, 7'd0, 3'b000, 1'b0);
    req = 3'b000;
    tick(3);
    checkOutput("final_gnt", 32'(gnt), 32'd0);
    checkOutput("final_busy", 32'(busy), 32'd0);
    checkOutput("scoreboard_drained", 32'(pixelQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
